branch_fetch_controller: RTL and testbench
==========================================

BRANCH_FETCH_CONTROLLER -- requirements
Module: branch_fetch_controller

Interface
REQ-001 The module SHALL have parameter CANT_BITS_ADDR, default 11, PC / instruction-memory address width.
REQ-002 The module SHALL have parameter CANT_BITS_INSTRUCTION, default 32, fetched instruction width.
REQ-003 The module SHALL have parameter CANT_BITS_CONTADOR, default 32, cycle and branch counter width.
REQ-004 The module SHALL have parameter HALT_INSTRUCTION, default 32'hFFFFFFFF, encoding that stops fetch.
REQ-005 The module SHALL have port i_clock  input  1  single clock, rising edge.
REQ-006 The module SHALL have port i_reset  input  1  asynchronous active-low reset.
REQ-007 The module SHALL have port i_start  input  1  one-cycle pulse, begin execution from address 0.
REQ-008 The module SHALL have port i_step_mode  input  1  1 = advance only on i_step; 0 = free-run.
REQ-009 The module SHALL have port i_step  input  1  one-cycle step request, used when i_step_mode=1.
REQ-010 The module SHALL have port i_stall  input  1  hazard stall from the hazard unit.
REQ-011 The module SHALL have port i_branch_control  input  1  redirect request from the branch address calculator.
REQ-012 The module SHALL have port i_branch_dir  input  CANT_BITS_ADDR  redirect target.
REQ-013 The module SHALL have port i_instruction  input  CANT_BITS_INSTRUCTION  instruction currently read at o_pc.
REQ-014 The module SHALL have port o_pc  output  CANT_BITS_ADDR  registered fetch address.
REQ-015 The module SHALL have port o_adder_pc  output  CANT_BITS_ADDR  o_pc+1 mod 2^CANT_BITS_ADDR, combinational, fed back to the branch calculator.
REQ-016 The module SHALL have port o_flush  output  1  combinational IF/ID bubble-insert strobe.
REQ-017 The module SHALL have ports o_running and o_halted  output  1 each  registered state flags.
REQ-018 The module SHALL have ports o_cycle_count and o_branch_count  output  CANT_BITS_CONTADOR each  registered counters.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and HALTED.
REQ-020 o_running SHALL equal (state==RUN); o_halted SHALL equal (state==HALTED).
REQ-021 IDLE or HALTED with i_start=1 SHALL load RUN, set o_pc=0, and clear both counters at that edge.
REQ-022 i_start SHALL be ignored in RUN.
REQ-023 Advance SHALL be defined as adv = RUN & !i_stall & (!i_step_mode | i_step).
REQ-024 No register other than the FSM on an i_start edge SHALL change when adv=0; o_pc SHALL hold.
REQ-025 On adv with i_branch_control=1, o_pc SHALL load i_branch_dir and o_branch_count SHALL increment.
REQ-026 On adv with i_branch_control=0 and i_instruction==HALT_INSTRUCTION, the FSM SHALL go to HALTED and o_pc SHALL hold.
REQ-027 On adv otherwise, o_pc SHALL load o_adder_pc, wrapping from 2^CANT_BITS_ADDR-1 to 0.
REQ-028 Branch SHALL take priority over HALT on the same cycle, since the fetched HALT is squashed.
REQ-029 o_flush SHALL equal adv & i_branch_control, the same cycle the PC redirects; it SHALL be 0 while stalled.
REQ-030 A branch during i_stall=1 SHALL be ignored; the held ID-stage instruction re-asserts it after the stall.
REQ-031 o_cycle_count SHALL increment on every adv cycle, including the HALT cycle.
REQ-032 Both counters SHALL saturate at all-ones, with no wrap.
REQ-033 i_step held high SHALL advance once per clock; edge detection is the debug unit's job.

Reset
REQ-034 i_reset=0 SHALL immediately, without waiting for a clock, force state=IDLE, o_pc=0, and both counters to 0; o_flush then SHALL be 0.
REQ-035 Reset asserted mid-RUN SHALL discard all in-flight state; after release the block SHALL remain in IDLE until i_start.

Verification
REQ-036 Reset, start, free-run, program of NOPs followed by HALT at address 5 -> o_pc sequence 0..5; o_halted=1 with o_pc=5 and o_cycle_count=6.
REQ-037 RUN at pc=3, i_branch_control=1, i_branch_dir=40 -> o_flush=1 that cycle; next o_pc=40; o_branch_count=1.
REQ-038 i_stall=1 for 3 cycles with i_branch_control=1 -> o_pc constant, o_flush=0, counters unchanged; branch taken on the first unstalled cycle.
REQ-039 Step mode with i_step pulsed twice over 10 cycles -> o_pc advances exactly 2 times; o_cycle_count=2.
REQ-040 Edge cases: o_pc=2047 -> 0 wrap; branch and HALT together -> redirect, stays RUN; i_reset low mid-run -> async IDLE, o_pc=0; i_start from HALTED -> restart at 0 with counters cleared.

Source files
------------

// File: rtl/branch_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : branch_fetch_controller
// Description : Instruction-fetch PC controller. It handles start, free-run
//               and single-step execution, hazard stalls, branch redirects
//               with an IF/ID flush, and HALT detection. It also keeps
//               saturating counters for cycles and taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_fetch_controller #(
    parameter int                               CANT_BITS_ADDR        = 11,
    parameter int                               CANT_BITS_INSTRUCTION = 32,
    parameter int                               CANT_BITS_CONTADOR    = 32,
    parameter logic [CANT_BITS_INSTRUCTION-1:0] HALT_INSTRUCTION      = 32'hFFFFFFFF
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic                             i_step_mode,
    input  logic                             i_step,
    input  logic                             i_stall,
    input  logic                             i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]        i_branch_dir,
    input  logic [CANT_BITS_INSTRUCTION-1:0] i_instruction,
    output logic [CANT_BITS_ADDR-1:0]        o_pc,
    output logic [CANT_BITS_ADDR-1:0]        o_adder_pc,
    output logic                             o_flush,
    output logic                             o_running,
    output logic                             o_halted,
    output logic [CANT_BITS_CONTADOR-1:0]    o_cycle_count,
    output logic [CANT_BITS_CONTADOR-1:0]    o_branch_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [CANT_BITS_ADDR-1:0]     c_pc_one  = {{(CANT_BITS_ADDR-1){1'b0}}, 1'b1};
    localparam logic [CANT_BITS_CONTADOR-1:0] c_cnt_one = {{(CANT_BITS_CONTADOR-1){1'b0}}, 1'b1};

    state_t                          r_state;
    logic [CANT_BITS_ADDR-1:0]       r_pc;
    logic [CANT_BITS_CONTADOR-1:0]   r_cycle_count;
    logic [CANT_BITS_CONTADOR-1:0]   r_branch_count;
    logic                            r_running;
    logic                            r_halted;

    logic                            w_adv;
    logic                            w_is_halt;
    logic [CANT_BITS_ADDR-1:0]       w_adder_pc;
    logic                            w_cycle_sat;
    logic                            w_branch_sat;

    // Advance qualifier and next-sequential PC (wraps naturally at the top)
    always_comb begin
        w_adv        = (r_state == ST_RUN) & ~i_stall & (~i_step_mode | i_step);
        w_is_halt    = (i_instruction == HALT_INSTRUCTION);
        w_adder_pc   = r_pc + c_pc_one;
        w_cycle_sat  = &r_cycle_count;
        w_branch_sat = &r_branch_count;
    end

    // FSM, PC and counters; the flags are registered alongside the state
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= ST_IDLE;
            r_pc           <= '0;
            r_cycle_count  <= '0;
            r_branch_count <= '0;
            r_running      <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (i_start) begin
                        r_state        <= ST_RUN;
                        r_running      <= 1'b1;
                        r_halted       <= 1'b0;
                        r_pc           <= '0;
                        r_cycle_count  <= '0;
                        r_branch_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_adv) begin
                        if (!w_cycle_sat) begin
                            r_cycle_count <= r_cycle_count + c_cnt_one;
                        end
                        // A branch squashes the fetched word, so it wins over HALT
                        if (i_branch_control) begin
                            r_pc <= i_branch_dir;
                            if (!w_branch_sat) begin
                                r_branch_count <= r_branch_count + c_cnt_one;
                            end
                        end else if (w_is_halt) begin
                            r_state   <= ST_HALTED;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end else begin
                            r_pc <= w_adder_pc;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    // A bubble is inserted only when the redirect actually happens
    always_comb begin
        o_flush = w_adv & i_branch_control;
    end

    assign o_pc           = r_pc;
    assign o_adder_pc     = w_adder_pc;
    assign o_running      = r_running;
    assign o_halted       = r_halted;
    assign o_cycle_count  = r_cycle_count;
    assign o_branch_count = r_branch_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_fetch_controller
// Description : Directed self-checking bench for branch_fetch_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_fetch_controller;

    localparam int AW = 11;
    localparam int IW = 32;
    localparam int CW = 32;
    localparam logic [IW-1:0] HALT = 32'hFFFFFFFF;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          step_mode;
    logic          step;
    logic          stall;
    logic          branch;
    logic [AW-1:0] branch_dir;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] adder_pc;
    logic          flush;
    logic          running;
    logic          halted;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] branch_cnt;

    logic [AW-1:0] s_pc;
    logic [AW-1:0] s_adder_pc;
    logic          s_flush;
    logic          s_running;
    logic          s_halted;
    logic [2:0]    s_cycle_cnt;
    logic [2:0]    s_branch_cnt;

    logic [IW-1:0] imem [0:2047];

    int checks   = 0;
    int failures = 0;

    branch_fetch_controller #(
        .CANT_BITS_ADDR(AW), .CANT_BITS_INSTRUCTION(IW),
        .CANT_BITS_CONTADOR(CW), .HALT_INSTRUCTION(HALT)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_branch_control(branch),
        .i_branch_dir(branch_dir), .i_instruction(instr), .o_pc(pc),
        .o_adder_pc(adder_pc), .o_flush(flush), .o_running(running),
        .o_halted(halted), .o_cycle_count(cycle_cnt), .o_branch_count(branch_cnt)
    );

    // Narrow-counter copy, driven identically, to exercise saturation
    branch_fetch_controller #(
        .CANT_BITS_ADDR(AW), .CANT_BITS_INSTRUCTION(IW),
        .CANT_BITS_CONTADOR(3), .HALT_INSTRUCTION(HALT)
    ) dut_sat (
        .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_branch_control(branch),
        .i_branch_dir(branch_dir), .i_instruction(instr), .o_pc(s_pc),
        .o_adder_pc(s_adder_pc), .o_flush(s_flush), .o_running(s_running),
        .o_halted(s_halted), .o_cycle_count(s_cycle_cnt), .o_branch_count(s_branch_cnt)
    );

    assign instr = imem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (pc !== 11'd0) begin failures++; $display("FAIL reset_pc actual=%0d expected=0", pc); end
        checks++; if (running !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_flags actual=%b%b expected=00", running, halted); end
        checks++; if (cycle_cnt !== 32'd0 || branch_cnt !== 32'd0) begin failures++; $display("FAIL reset_counts actual=%0d/%0d expected=0/0", cycle_cnt, branch_cnt); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush actual=%b expected=0", flush); end
        rst_n = 1'b1;
        tick();
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL idle_hold actual=%b expected=0", running); end
    endtask

    task automatic test_free_run();
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            checks++; if (pc !== AW'(k)) begin failures++; $display("FAIL freerun_pc step=%0d actual=%0d expected=%0d", k, pc, k); end
            tick();
        end
        checks++; if (halted !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL halt_flags actual=%b%b expected=01", running, halted); end
        checks++; if (pc !== 11'd5) begin failures++; $display("FAIL halt_pc actual=%0d expected=5", pc); end
        checks++; if (cycle_cnt !== 32'd6) begin failures++; $display("FAIL halt_cycles actual=%0d expected=6", cycle_cnt); end
        tick();
        checks++; if (pc !== 11'd5 || cycle_cnt !== 32'd6) begin failures++; $display("FAIL halted_hold actual=%0d/%0d expected=5/6", pc, cycle_cnt); end
    endtask

    task automatic test_branch();
        pulse_start();
        tick(); tick(); tick();
        checks++; if (pc !== 11'd3) begin failures++; $display("FAIL pre_branch_pc actual=%0d expected=3", pc); end
        checks++; if (adder_pc !== 11'd4) begin failures++; $display("FAIL adder_pc actual=%0d expected=4", adder_pc); end
        branch = 1'b1; branch_dir = 11'd40;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL branch_flush actual=%b expected=1", flush); end
        tick();
        branch = 1'b0;
        checks++; if (pc !== 11'd40) begin failures++; $display("FAIL branch_pc actual=%0d expected=40", pc); end
        checks++; if (branch_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin failures++; $display("FAIL branch_counts actual=%0d/%0d expected=1/4", branch_cnt, cycle_cnt); end
    endtask

    task automatic test_stall_branch();
        stall = 1'b1; branch = 1'b1; branch_dir = 11'd100;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (flush !== 1'b0) begin failures++; $display("FAIL stall_flush cyc=%0d actual=%b expected=0", k, flush); end
            tick();
            checks++; if (pc !== 11'd40 || cycle_cnt !== 32'd4 || branch_cnt !== 32'd1) begin failures++; $display("FAIL stall_hold cyc=%0d actual=%0d/%0d/%0d expected=40/4/1", k, pc, cycle_cnt, branch_cnt); end
        end
        stall = 1'b0;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL unstall_flush actual=%b expected=1", flush); end
        tick();
        branch = 1'b0;
        checks++; if (pc !== 11'd100 || branch_cnt !== 32'd2 || cycle_cnt !== 32'd5) begin failures++; $display("FAIL unstall_branch actual=%0d/%0d/%0d expected=100/2/5", pc, branch_cnt, cycle_cnt); end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 11'd0 || running !== 1'b0 || cycle_cnt !== 32'd0 || branch_cnt !== 32'd0) begin failures++; $display("FAIL async_reset actual=%0d/%b/%0d/%0d expected=0/0/0/0", pc, running, cycle_cnt, branch_cnt); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL async_reset_flush actual=%b expected=0", flush); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (running !== 1'b0 || pc !== 11'd0) begin failures++; $display("FAIL post_reset_idle actual=%b/%0d expected=0/0", running, pc); end
    endtask

    task automatic test_step();
        step_mode = 1'b1;
        pulse_start();
        for (int k = 0; k < 10; k++) begin
            step = (k == 2 || k == 6);
            tick();
        end
        step = 1'b0;
        checks++; if (pc !== 11'd2 || cycle_cnt !== 32'd2) begin failures++; $display("FAIL step_pulses actual=%0d/%0d expected=2/2", pc, cycle_cnt); end
        step = 1'b1;
        tick(); tick(); tick();
        step = 1'b0;
        tick();
        checks++; if (pc !== 11'd5 || cycle_cnt !== 32'd5) begin failures++; $display("FAIL step_held actual=%0d/%0d expected=5/5", pc, cycle_cnt); end
        step_mode = 1'b0;
    endtask

    task automatic test_wrap();
        branch = 1'b1; branch_dir = 11'd2047;
        tick();
        branch = 1'b0;
        checks++; if (pc !== 11'd2047 || adder_pc !== 11'd0) begin failures++; $display("FAIL wrap_top actual=%0d/%0d expected=2047/0", pc, adder_pc); end
        tick();
        checks++; if (pc !== 11'd0) begin failures++; $display("FAIL wrap_zero actual=%0d expected=0", pc); end
    endtask

    task automatic test_branch_halt_restart();
        branch = 1'b1; branch_dir = 11'd10;
        tick();
        branch_dir = 11'd20;
        #1;
        checks++; if (instr !== HALT || flush !== 1'b1) begin failures++; $display("FAIL br_halt_flush actual=%b expected=1", flush); end
        tick();
        checks++; if (pc !== 11'd20 || running !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL br_halt_prio actual=%0d/%b/%b expected=20/1/0", pc, running, halted); end
        branch_dir = 11'd5;
        tick();
        branch = 1'b0;
        tick();
        checks++; if (halted !== 1'b1 || pc !== 11'd5) begin failures++; $display("FAIL rehalt actual=%b/%0d expected=1/5", halted, pc); end
        pulse_start();
        checks++; if (pc !== 11'd0 || running !== 1'b1 || cycle_cnt !== 32'd0 || branch_cnt !== 32'd0) begin failures++; $display("FAIL restart actual=%0d/%b/%0d/%0d expected=0/1/0/0", pc, running, cycle_cnt, branch_cnt); end
        tick();
        pulse_start();
        checks++; if (pc !== 11'd2 || cycle_cnt !== 32'd2) begin failures++; $display("FAIL start_in_run actual=%0d/%0d expected=2/2", pc, cycle_cnt); end
    endtask

    task automatic test_saturation();
        branch = 1'b1; branch_dir = 11'd1;
        for (int k = 0; k < 9; k++) tick();
        branch = 1'b0;
        checks++; if (cycle_cnt !== 32'd11 || branch_cnt !== 32'd9) begin failures++; $display("FAIL wide_counts actual=%0d/%0d expected=11/9", cycle_cnt, branch_cnt); end
        checks++; if (s_cycle_cnt !== 3'd7 || s_branch_cnt !== 3'd7) begin failures++; $display("FAIL sat_counts actual=%0d/%0d expected=7/7", s_cycle_cnt, s_branch_cnt); end
        checks++; if (s_pc !== 11'd1 || s_running !== 1'b1) begin failures++; $display("FAIL sat_pc actual=%0d/%b expected=1/1", s_pc, s_running); end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) imem[a] = 32'h0000_0013;
        imem[5]  = HALT;
        imem[10] = HALT;
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        stall = 1'b0; branch = 1'b0; branch_dir = '0;
        test_reset();
        test_free_run();
        test_branch();
        test_stall_branch();
        test_async_reset();
        test_step();
        test_wrap();
        test_branch_halt_restart();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
